// File: rtl/pla_ibm_pkg.sv
// Shared constants, FSM state type and lane interleave helper for the
// PLA IBM select-lane pair packer.
package pla_ibm_pkg;

  localparam int PLA_IBM_LANES  = 15;
  localparam int PLA_IBM_PAIR_W = 30;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HAVE_LO = 2'd1,
    ST_HAVE_HI = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  // Lane k lands on bit 2k (low half) and bit 2k+1 (high half).
  function automatic logic [PLA_IBM_PAIR_W-1:0] pla_ibm_interleave(
    input logic [PLA_IBM_LANES-1:0] lo,
    input logic [PLA_IBM_LANES-1:0] hi
  );
    logic [PLA_IBM_PAIR_W-1:0] p;
    p = '0;
    for (int k = 0; k < PLA_IBM_LANES; k++) begin
      p[2*k]   = lo[k];
      p[2*k+1] = hi[k];
    end
    return p;
  endfunction

endpackage

// File: rtl/pla_ibm_pair_packer.sv
// Packs a low and a high 15-lane half-word into one interleaved 30-bit pair.
// Optional parity on the output pair is enabled by PLA_IBM_PACK_PARITY_EN.
module pla_ibm_pair_packer
  import pla_ibm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_data,
  input  logic        in_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] out_pair,
  output logic        out_par,
  output logic        dup_err,
  input  logic        clr_err,
  output logic [7:0]  pair_cnt,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and out_pair is held while
  // out_valid is high and out_ready is low.
  state_t                   state_q, state_d;
  logic [PLA_IBM_LANES-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                     dup_err_q, dup_err_d;
  logic [7:0]               pair_cnt_q, pair_cnt_d;
  logic                     in_hs, out_hs, dup_set;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = (state_q != ST_FULL) | out_ready;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dup_set = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          if (in_hi) begin
            hi_d    = in_data;
            state_d = ST_HAVE_HI;
          end else begin
            lo_d    = in_data;
            state_d = ST_HAVE_LO;
          end
        end
      end
      ST_HAVE_LO: begin
        if (in_hs) begin
          if (in_hi) begin
            hi_d    = in_data;
            state_d = ST_FULL;
          end else begin
            lo_d    = in_data;
            dup_set = 1'b1;
          end
        end
      end
      ST_HAVE_HI: begin
        if (in_hs) begin
          if (!in_hi) begin
            lo_d    = in_data;
            state_d = ST_FULL;
          end else begin
            hi_d    = in_data;
            dup_set = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // A new half can only arrive here alongside a drain.
        if (out_hs) begin
          if (in_hs) begin
            if (in_hi) begin
              hi_d    = in_data;
              lo_d    = '0;
              state_d = ST_HAVE_HI;
            end else begin
              lo_d    = in_data;
              hi_d    = '0;
              state_d = ST_HAVE_LO;
            end
          end else begin
            lo_d    = '0;
            hi_d    = '0;
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    dup_err_d  = clr_err ? 1'b0 : (dup_err_q | dup_set);
    pair_cnt_d = pair_cnt_q + {7'd0, out_hs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      lo_q       <= '0;
      hi_q       <= '0;
      dup_err_q  <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dup_err_q  <= dup_err_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

`ifdef PLA_IBM_PACK_PARITY_EN
  logic par_q, par_d;

  assign par_d = ^{hi_d, lo_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign out_par = par_q;
`else
  assign out_par = 1'b0;
`endif

  assign out_pair  = pla_ibm_interleave(lo_q, hi_q);
  assign dup_err   = dup_err_q;
  assign pair_cnt  = pair_cnt_q;
  assign dbg_state = state_q;

endmodule
